// File: rtl/drum_mult_pipe.sv
// drum_mult_pipe: three-stage elastic multiplier returning either a DRUM
// approximate product (K-bit mantissas, LSB forced to 1) or the exact product,
// chosen per transaction. Results leave in acceptance order.
module drum_mult_pipe #(
  parameter int unsigned WIDTH  = 16,
  parameter int unsigned K      = 6,
  parameter int unsigned SIGNED = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  input  logic                 approx_en,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   r
);

  localparam int unsigned PW  = 2 * WIDTH;
  localparam int unsigned MW  = 2 * K;
  localparam int unsigned KW  = $clog2(WIDTH);
  localparam int unsigned SHW = $clog2(PW);
  localparam logic [KW-1:0] K_IDX    = KW'(K);
  localparam logic [KW-1:0] K_M1_IDX = KW'(K - 1);

  // Magnitude of an operand; the most negative value maps to 2^(WIDTH-1).
  function automatic logic [WIDTH-1:0] mag_of(input logic [WIDTH-1:0] x);
    if ((SIGNED != 0) && x[WIDTH-1]) mag_of = -x;
    else                              mag_of = x;
  endfunction

  // Index of the highest set bit, 0 for a zero magnitude.
  function automatic logic [KW-1:0] lead_one(input logic [WIDTH-1:0] x);
    lead_one = '0;
    for (int i = 0; i < int'(WIDTH); i++) begin
      if (x[i]) lead_one = KW'(i);
    end
  endfunction

  // DRUM mantissa: K bits starting at the leading one, LSB forced high.
  function automatic logic [K-1:0] mant_of(input logic [WIDTH-1:0] x,
                                           input logic [KW-1:0]    k);
    logic [K-1:0] m;
    if (k >= K_IDX) begin
      m    = K'(x >> (k - K_M1_IDX));
      m[0] = 1'b1;
    end else begin
      m = x[K-1:0];
    end
    mant_of = m;
  endfunction

  // Left shift that restores the scale of a DRUM mantissa.
  function automatic logic [SHW-1:0] shift_of(input logic [KW-1:0] k);
    if (k >= K_IDX) shift_of = SHW'(k - K_M1_IDX);
    else            shift_of = '0;
  endfunction

  // Stage registers
  logic               r_v1, r_v2, r_v3;
  logic               r_sign1, r_apx1, r_sign2;
  logic [WIDTH-1:0]   r_mag_a, r_mag_b;
  logic [KW-1:0]      r_ka, r_kb;
  logic [PW-1:0]      r_prod;
  logic [SHW-1:0]     r_shift;
  logic [PW-1:0]      r_res;

  // Combinational datapath
  logic               w_ready1, w_ready2, w_ready3;
  logic [WIDTH-1:0]   w_mag_a, w_mag_b;
  logic               w_sign;
  logic [K-1:0]       w_mant_a, w_mant_b;
  logic [MW-1:0]      w_prod_apx;
  logic [PW-1:0]      w_prod_exact;
  logic [SHW-1:0]     w_shift_sum;
  logic [PW-1:0]      w_mag_out;
  logic [PW-1:0]      w_res;

  // A stage can load when empty or when the stage after it moves on.
  assign w_ready3 = !r_v3 || out_ready;
  assign w_ready2 = !r_v2 || w_ready3;
  assign w_ready1 = !r_v1 || w_ready2;
  assign in_ready = w_ready1;

  assign w_mag_a = mag_of(a);
  assign w_mag_b = mag_of(b);
  assign w_sign  = (SIGNED != 0) && (a[WIDTH-1] ^ b[WIDTH-1]);

  assign w_mant_a     = mant_of(r_mag_a, r_ka);
  assign w_mant_b     = mant_of(r_mag_b, r_kb);
  assign w_prod_apx   = MW'(w_mant_a) * MW'(w_mant_b);
  assign w_prod_exact = PW'(r_mag_a) * PW'(r_mag_b);
  assign w_shift_sum  = shift_of(r_ka) + shift_of(r_kb);

  assign w_mag_out = r_prod << r_shift;
  assign w_res     = r_sign2 ? -w_mag_out : w_mag_out;

  assign out_valid = r_v3;
  assign r         = r_res;

  // S1: capture sign, magnitudes, mode and leading-one positions.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_v1    <= 1'b0;
      r_sign1 <= 1'b0;
      r_apx1  <= 1'b0;
      r_mag_a <= '0;
      r_mag_b <= '0;
      r_ka    <= '0;
      r_kb    <= '0;
    end else if (w_ready1) begin
      r_v1 <= in_valid;
      if (in_valid) begin
        r_sign1 <= w_sign;
        r_apx1  <= approx_en;
        r_mag_a <= w_mag_a;
        r_mag_b <= w_mag_b;
        r_ka    <= lead_one(w_mag_a);
        r_kb    <= lead_one(w_mag_b);
      end
    end
  end

  // S2: multiply mantissas (approx) or full magnitudes (exact).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_v2    <= 1'b0;
      r_sign2 <= 1'b0;
      r_prod  <= '0;
      r_shift <= '0;
    end else if (w_ready2) begin
      r_v2 <= r_v1;
      if (r_v1) begin
        r_sign2 <= r_sign1;
        r_prod  <= r_apx1 ? PW'(w_prod_apx) : w_prod_exact;
        r_shift <= r_apx1 ? w_shift_sum : '0;
      end
    end
  end

  // S3: rescale and apply sign; held stable while the consumer stalls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_v3  <= 1'b0;
      r_res <= '0;
    end else if (w_ready3) begin
      r_v3 <= r_v2;
      if (r_v2) r_res <= w_res;
    end
  end

endmodule

// File: tb/tb_drum_mult_pipe.sv
// Bench for drum_mult_pipe: two instances (16/6 signed, 12/4 unsigned) share
// handshake stimulus; an arithmetic reference model plus in-order queues
// predicts every result.
module tb_drum_mult_pipe;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        approx_en;
  logic        out_ready;
  logic [15:0] a1, b1;
  logic [11:0] a2, b2;
  logic        ir1, ir2, ov1, ov2;
  logic [31:0] r1;
  logic [23:0] r2;

  int          checks;
  int          errors;
  logic [63:0] q1[$];
  logic [63:0] q2[$];
  logic [31:0] got[$];
  bit          log_en;
  bit          st1, st2;
  logic [31:0] held1;
  logic [23:0] held2;
  logic [63:0] e1, e2;

  drum_mult_pipe #(.WIDTH(16), .K(6), .SIGNED(1)) u_dut16 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir1),
    .a(a1), .b(b1), .approx_en(approx_en), .out_valid(ov1),
    .out_ready(out_ready), .r(r1));

  drum_mult_pipe #(.WIDTH(12), .K(4), .SIGNED(0)) u_dut12 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir2),
    .a(a2), .b(b2), .approx_en(approx_en), .out_valid(ov2),
    .out_ready(out_ready), .r(r2));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", nm, act, exp);
    end
  endtask

  // DRUM approximation of a magnitude as a value: keep kk bits from the
  // leading one, force the lowest kept bit, zero everything below.
  function automatic longint unsigned drum_val(input longint unsigned x, input int kk);
    int k;
    int s;
    if (x == 0) return 0;
    k = 0;
    for (int i = 0; i < 64; i++) if (x[i]) k = i;
    if (k < kk) return x;
    s = k - kk + 1;
    return ((x >> s) | 64'd1) << s;
  endfunction

  // Product as a 2w-bit two's-complement pattern.
  function automatic logic [63:0] model(input int w, input int kk, input bit sgn,
                                        input bit apx, input logic [31:0] a,
                                        input logic [31:0] b);
    longint unsigned ua, ub, ma, mb, p, mask_in, mask_out;
    bit na, nb;
    mask_in  = (64'd1 << w) - 64'd1;
    mask_out = (w == 32) ? '1 : ((64'd1 << (2 * w)) - 64'd1);
    ua = 64'(a) & mask_in;
    ub = 64'(b) & mask_in;
    na = sgn && ua[w-1];
    nb = sgn && ub[w-1];
    ma = na ? (64'd1 << w) - ua : ua;
    mb = nb ? (64'd1 << w) - ub : ub;
    if (apx) begin
      ma = drum_val(ma, kk);
      mb = drum_val(mb, kk);
    end
    p = ma * mb;
    if (na != nb) p = -p;
    return p & mask_out;
  endfunction

  function automatic logic [31:0] pick(input int w);
    logic [31:0] mask;
    mask = (32'd1 << w) - 32'd1;
    case ($urandom_range(0, 7))
      0:       return 32'd0;
      1:       return 32'd1 << (w - 1);
      2:       return mask;
      3:       return mask >> 1;
      4:       return 32'($urandom_range(0, 63));
      default: return $urandom & mask;
    endcase
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Single transaction into an empty pipe with out_ready high; checks latency.
  task automatic one(input logic [15:0] a, input logic [15:0] b, input logic apx,
                     input logic [31:0] exp, input string nm);
    a1 = a; b1 = b; a2 = a[11:0]; b2 = b[11:0]; approx_en = apx; in_valid = 1'b1;
    chk({nm, "_ready"}, 64'(ir1), 64'd1);
    tick();
    in_valid = 1'b0;
    tick();
    chk({nm, "_early"}, 64'(ov1), 64'd0);
    tick();
    chk({nm, "_valid"}, 64'(ov1), 64'd1);
    chk(nm, 64'(r1), 64'(exp));
    tick();
    tick();
  endtask

  // Monitor: predicts at acceptance, compares at every output transfer,
  // checks that stalled outputs hold; reset discards all predictions.
  always @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q1.delete();
      q2.delete();
      st1 = 1'b0;
      st2 = 1'b0;
    end else begin
      if (st1) chk("hold16", 64'({ov1, r1}), 64'({1'b1, held1}));
      if (st2) chk("hold12", 64'({ov2, r2}), 64'({1'b1, held2}));
      if (ov1 && out_ready) begin
        if (q1.size() == 0) chk("spurious16", 64'(q1.size()), 64'd1);
        else begin
          e1 = q1.pop_front();
          chk("r16", 64'(r1), e1);
        end
        if (log_en) got.push_back(r1);
      end
      if (ov2 && out_ready) begin
        if (q2.size() == 0) chk("spurious12", 64'(q2.size()), 64'd1);
        else begin
          e2 = q2.pop_front();
          chk("r12", 64'(r2), e2);
        end
      end
      st1   = ov1 && !out_ready;
      st2   = ov2 && !out_ready;
      held1 = r1;
      held2 = r2;
      if (in_valid && ir1) q1.push_back(model(16, 6, 1, approx_en, 32'(a1), 32'(b1)));
      if (in_valid && ir2) q2.push_back(model(12, 4, 0, approx_en, 32'(a2), 32'(b2)));
    end
  end

  initial begin
    int idx;
    int acc;
    logic [31:0] bp_exp [6];
    checks = 0; errors = 0; log_en = 1'b0;
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1; approx_en = 1'b0;
    a1 = '0; b1 = '0; a2 = '0; b2 = '0;
    bp_exp = '{32'd2, 32'd6, 32'd12, 32'd20, 32'd30, 32'd42};

    // Hand-computed values pinning the reference model.
    chk("model_apx1000", model(16, 6, 1, 1, 32'd1000, 32'd1000), 64'd1016064);
    chk("model_small",   model(16, 6, 1, 1, 32'd37, 32'd21), 64'd777);
    chk("model_negapx",  model(16, 6, 1, 1, 32'h0000FC18, 32'd1000), 64'hFFF07F00);
    chk("model_negex",   model(16, 6, 1, 0, 32'h0000FC18, 32'd1000), 64'hFFF0BDC0);
    chk("model_minneg",  model(16, 6, 1, 0, 32'h00008000, 32'h00008000), 64'h40000000);
    chk("model_w12",     model(12, 4, 0, 1, 32'd100, 32'd100), 64'd10816);

    // Reset state.
    #12;
    chk("rst_valid", 64'(ov1), 64'd0);
    chk("rst_r", 64'(r1), 64'd0);
    chk("rst_ready", 64'(ir1), 64'd1);

    // First pair is offered during reset and accepted on the first edge after release.
    a1 = 16'd1000; b1 = 16'd1000; a2 = 12'd100; b2 = 12'd100;
    approx_en = 1'b1; in_valid = 1'b1;
    @(posedge clk);
    #3;
    rst_n = 1'b1;
    chk("post_rst_ready", 64'(ir1), 64'd1);
    tick();
    in_valid = 1'b0;
    tick();
    chk("first_early", 64'(ov1), 64'd0);
    tick();
    chk("first_valid", 64'(ov1), 64'd1);
    chk("first_r16", 64'(r1), 64'd1016064);
    chk("first_r12", 64'(r2), 64'd10816);
    tick();
    tick();

    one(16'd37,    16'd21,    1'b1, 32'd777,        "small");
    one(16'd0,     16'hFFFB,  1'b1, 32'd0,          "zero");
    one(16'hFC18,  16'd1000,  1'b1, 32'hFFF07F00,   "neg_apx");
    one(16'hFC18,  16'd1000,  1'b0, 32'hFFF0BDC0,   "neg_exact");
    one(16'h8000,  16'h8000,  1'b0, 32'h40000000,   "minneg");

    // Backpressure: six pairs (n, n+1) against a stalled consumer.
    got.delete();
    log_en = 1'b1;
    out_ready = 1'b0;
    idx = 1;
    acc = 0;
    for (int c = 0; c < 6; c++) begin
      in_valid = (idx <= 6);
      a1 = 16'(idx); b1 = 16'(idx + 1); a2 = 12'(idx); b2 = 12'(idx + 1);
      approx_en = 1'b1;
      @(negedge clk);
      if (in_valid && ir1) begin idx++; acc++; end
      tick();
    end
    chk("bp_accepts", 64'(acc), 64'd3);
    chk("bp_ready", 64'(ir1), 64'd0);
    chk("bp_hold_valid", 64'(ov1), 64'd1);
    chk("bp_hold_r", 64'(r1), 64'd2);
    out_ready = 1'b1;
    for (int c = 0; c < 20 && idx <= 6; c++) begin
      in_valid = 1'b1;
      a1 = 16'(idx); b1 = 16'(idx + 1); a2 = 12'(idx); b2 = 12'(idx + 1);
      @(negedge clk);
      if (ir1) idx++;
      tick();
    end
    in_valid = 1'b0;
    repeat (6) tick();
    log_en = 1'b0;
    chk("bp_count", 64'(got.size()), 64'd6);
    for (int i = 0; i < 6; i++) begin
      if (i < got.size()) chk($sformatf("bp_order%0d", i), 64'(got[i]), 64'(bp_exp[i]));
    end

    // Reset with three transactions in flight.
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1;
      a1 = 16'(300 + i); b1 = 16'(500 + i); a2 = 12'(30 + i); b2 = 12'(50 + i);
      tick();
    end
    in_valid = 1'b0;
    chk("inflight_valid", 64'(ov1), 64'd1);
    rst_n = 1'b0;
    #1;
    chk("midrst_valid", 64'(ov1), 64'd0);
    chk("midrst_r", 64'(r1), 64'd0);
    chk("midrst_ready", 64'(ir1), 64'd1);
    chk("midrst_valid12", 64'(ov2), 64'd0);
    #1;
    rst_n = 1'b1;
    out_ready = 1'b1;
    got.delete();
    log_en = 1'b1;
    repeat (8) tick();
    log_en = 1'b0;
    chk("midrst_no_old", 64'(got.size()), 64'd0);
    one(16'd1000, 16'd1000, 1'b1, 32'd1016064, "after_rst");

    // Randomised traffic with random handshakes on both sides.
    for (int c = 0; c < 14000; c++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      approx_en = 1'($urandom_range(0, 1));
      a1 = 16'(pick(16)); b1 = 16'(pick(16));
      a2 = 12'(pick(12)); b2 = 12'(pick(12));
      tick();
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int c = 0; c < 40 && (q1.size() != 0 || q2.size() != 0); c++) tick();
    chk("drain16", 64'(q1.size()), 64'd0);
    chk("drain12", 64'(q2.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
